updown_count_monitor: RTL and testbench

Receive-side companion to updown_counter. It samples a counter value stream and recovers the following from it:
- the start (init) value;
- the count direction;
- wrap-around events;
- illegal steps.

It sits beside the counter, or downstream of any bus carrying its count, as an in-system checker/decoder. All outputs are registered.

---
 rtl/updown_count_monitor_if.sv | 28 ++
 rtl/updown_count_monitor.sv | 149 ++++++++++++++
 tb/tb_updown_count_monitor.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/updown_count_monitor_if.sv
// Signal bundle between a count source and updown_count_monitor.
// The master drives the sampled count and qualifiers; the slave (the monitor) returns the decoded status.
interface updown_count_monitor_if #(
  parameter int WIDTH = 8,
  parameter int RUN_W = 16
);
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] count;
  logic             locked;
  logic             dir;
  logic [WIDTH-1:0] init_val;
  logic             dir_chg;
  logic             wrap;
  logic             err;
  logic [7:0]       err_cnt;
  logic [RUN_W-1:0] run_len;

  modport master (
    output en, clr, count,
    input  locked, dir, init_val, dir_chg, wrap, err, err_cnt, run_len
  );

  modport slave (
    input  en, clr, count,
    output locked, dir, init_val, dir_chg, wrap, err, err_cnt, run_len
  );
endinterface

// File: rtl/updown_count_monitor.sv
// Decodes an up/down counter stream: init value, direction, wraps, illegal steps.
// Define MON_HALT_ON_ERR_EN to freeze the monitor in HALT on the first illegal step until clr.
module updown_count_monitor #(
  parameter int WIDTH = 8,
  parameter int RUN_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  updown_count_monitor_if.slave mon
);

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_UP, S_DOWN, S_HALT} state_e;
  typedef enum logic [1:0] {STEP_HOLD, STEP_UP, STEP_DN, STEP_BAD} step_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [WIDTH-1:0]   init_val_q, init_val_d;
  logic               dir_q, dir_d;
  logic [RUN_W-1:0]   run_len_q, run_len_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic               dir_chg_q, dir_chg_d;
  logic               wrap_q, wrap_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   delta;
  step_e              step;
  logic               err_inc;
  logic               step_up;

  always_comb begin
    delta = mon.count - prev_q;
    if (delta == '0)
      step = STEP_HOLD;
    else if (delta == WIDTH'(1))
      step = STEP_UP;
    else if (delta == '1)
      step = STEP_DN;
    else
      step = STEP_BAD;
  end

  // NOTE: every output of this block gets a default first so no path leaves a value unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    init_val_d = init_val_q;
    dir_d      = dir_q;
    run_len_d  = run_len_q;
    dir_chg_d  = 1'b0;
    wrap_d     = 1'b0;
    err_inc    = 1'b0;
    step_up    = (step == STEP_UP);

    if (mon.en && state_q != S_HALT) begin
      prev_d = mon.count;
      wrap_d = (state_q != S_IDLE) &&
               ((step == STEP_UP && prev_q == '1) || (step == STEP_DN && prev_q == '0));
      unique case (state_q)
        S_IDLE: begin
          init_val_d = mon.count;
          state_d    = S_PRIME;
        end
        S_PRIME: begin
          if (step == STEP_UP || step == STEP_DN) begin
            state_d   = step_up ? S_UP : S_DOWN;
            dir_d     = step_up;
            run_len_d = RUN_W'(1);
          end else if (step == STEP_BAD) begin
            err_inc = 1'b1;
          end
        end
        S_UP, S_DOWN: begin
          if (step == STEP_BAD) begin
            err_inc   = 1'b1;
            state_d   = S_PRIME;
            run_len_d = '0;
          end else if (step != STEP_HOLD) begin
            // dir_q always matches UP/DOWN while locked, so it tells continuation from reversal.
            if (step_up == dir_q) begin
              if (run_len_q != '1)
                run_len_d = run_len_q + 1'b1;
            end else begin
              dir_chg_d = 1'b1;
              dir_d     = step_up;
              run_len_d = RUN_W'(1);
              state_d   = step_up ? S_UP : S_DOWN;
            end
          end
        end
        default: ;
      endcase
`ifdef MON_HALT_ON_ERR_EN
      if (err_inc) begin
        state_d   = S_HALT;
        run_len_d = '0;
      end
`endif
    end

`ifdef MON_HALT_ON_ERR_EN
    if (state_q == S_HALT && mon.clr)
      state_d = S_IDLE;
`endif

    err_d = err_inc;
    // clr outranks a coincident illegal step for the counter, not for the pulse.
    if (mon.clr)
      err_cnt_d = '0;
    else if (err_inc && err_cnt_q != '1)
      err_cnt_d = err_cnt_q + 8'd1;
    else
      err_cnt_d = err_cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      prev_q     <= '0;
      init_val_q <= '0;
      dir_q      <= 1'b0;
      run_len_q  <= '0;
      err_cnt_q  <= '0;
      dir_chg_q  <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      init_val_q <= init_val_d;
      dir_q      <= dir_d;
      run_len_q  <= run_len_d;
      err_cnt_q  <= err_cnt_d;
      dir_chg_q  <= dir_chg_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
    end
  end

  assign mon.locked   = (state_q == S_UP) || (state_q == S_DOWN);
  assign mon.dir      = dir_q;
  assign mon.init_val = init_val_q;
  assign mon.dir_chg  = dir_chg_q;
  assign mon.wrap     = wrap_q;
  assign mon.err      = err_q;
  assign mon.err_cnt  = err_cnt_q;
  assign mon.run_len  = run_len_q;

endmodule

// File: tb/tb_updown_count_monitor.sv
// Randomized and directed bench for updown_count_monitor against a step-rule reference model.
// A narrow RUN_W is used so run-length saturation is reachable in a short run.
module tb_updown_count_monitor;

  localparam int WIDTH   = 8;
  localparam int RUN_W   = 4;
  localparam int RUN_MAX = (1 << RUN_W) - 1;
  localparam int MOD     = 1 << WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;

  updown_count_monitor_if #(.WIDTH(WIDTH), .RUN_W(RUN_W)) mon_if ();

  updown_count_monitor #(.WIDTH(WIDTH), .RUN_W(RUN_W)) dut (
    .clk (clk),
    .rst (rst),
    .mon (mon_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what an observer concludes from the sample history.
  bit m_started, m_locked, m_dir, m_halted;
  bit m_wrap, m_err, m_dirchg;
  int m_prev, m_init, m_run, m_errcnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_locked = 0; m_dir = 0; m_halted = 0;
    m_wrap = 0; m_err = 0; m_dirchg = 0;
    m_prev = 0; m_init = 0; m_run = 0; m_errcnt = 0;
  endtask

  task automatic model_edge(input bit en, input bit clr, input int cnt);
    int  d;
    bit  bad;
    bit  up;
    m_wrap = 0; m_err = 0; m_dirchg = 0; bad = 0;
    if (m_halted) begin
      if (clr) begin
        m_halted  = 0;
        m_started = 0;
        m_errcnt  = 0;
      end
      return;
    end
    if (en) begin
      if (!m_started) begin
        m_started = 1;
        m_init    = cnt;
        m_prev    = cnt;
      end else begin
        d = (cnt - m_prev + MOD) % MOD;
        if ((d == 1 && m_prev == MOD - 1) || (d == MOD - 1 && m_prev == 0))
          m_wrap = 1;
        if (d == 1 || d == MOD - 1) begin
          up = (d == 1);
          if (m_locked && up == m_dir) begin
            m_run = (m_run < RUN_MAX) ? m_run + 1 : RUN_MAX;
          end else begin
            if (m_locked) m_dirchg = 1;
            m_locked = 1;
            m_dir    = up;
            m_run    = 1;
          end
        end else if (d != 0) begin
          m_err    = 1;
          bad      = 1;
          m_locked = 0;
          m_run    = 0;
`ifdef MON_HALT_ON_ERR_EN
          m_halted = 1;
`endif
        end
        m_prev = cnt;
      end
    end
    if (clr)
      m_errcnt = 0;
    else if (bad && m_errcnt < 255)
      m_errcnt++;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".locked"},   mon_if.locked,   m_locked);
    check({tag, ".dir"},      mon_if.dir,      m_dir);
    check({tag, ".init_val"}, mon_if.init_val, m_init);
    check({tag, ".dir_chg"},  mon_if.dir_chg,  m_dirchg);
    check({tag, ".wrap"},     mon_if.wrap,     m_wrap);
    check({tag, ".err"},      mon_if.err,      m_err);
    check({tag, ".err_cnt"},  mon_if.err_cnt,  m_errcnt);
    check({tag, ".run_len"},  mon_if.run_len,  m_run);
  endtask

  task automatic cycle(input string tag, input bit en, input bit clr, input int cnt);
    @(negedge clk);
    mon_if.en    = en;
    mon_if.clr   = clr;
    mon_if.count = cnt[WIDTH-1:0];
    @(posedge clk);
    model_edge(en, clr, cnt);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    mon_if.en  = 1'b0;
    mon_if.clr = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int cnt;
    int r;
    int k;
    model_reset();
    mon_if.en    = 1'b0;
    mon_if.clr   = 1'b0;
    mon_if.count = '0;
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b1;

    // Lock-up from an arbitrary start value.
    for (int i = 0; i < 4; i++) cycle("t1", 1, 0, 'h81 + i);

    // Up wrap MAX -> 0.
    do_reset("t2rst");
    for (int i = 0; i < 4; i++) cycle("t2", 1, 0, ('hFE + i) % MOD);

    // Reversal, then illegal jump and a down wrap.
    do_reset("t3rst");
    for (int i = 0; i < 4; i++) cycle("t3up", 1, 0, 'h8D + i);
    cycle("t3dn", 1, 0, 'h8F);
    cycle("t3dn", 1, 0, 'h8E);
    cycle("t3bad", 1, 0, 'h01);
    cycle("t3dn", 1, 0, 'h00);
    cycle("t3wrap", 1, 0, 'hFF);

    // Illegal step out of lock, then relock.
    do_reset("t4rst");
    for (int i = 0; i < 3; i++) cycle("t4up", 1, 0, 'h3E + i);
    cycle("t4bad", 1, 0, 'h45);
    cycle("t4relock", 1, 0, 'h46);

    // Holds and en gaps, then reset mid-stream.
    do_reset("t5rst");
    for (int i = 0; i < 4; i++) cycle("t5up", 1, 0, 'h30 + i);
    for (int i = 0; i < 8; i++) cycle("t5hold", !(i >= 2 && i < 5), 0, (i == 3) ? 'h99 : 'h33);
    do_reset("t5midrst");
    cycle("t5recap", 1, 0, 'h10);
    cycle("t5recap2", 1, 0, 'h11);

    // clr coincident with an illegal step.
    cycle("clrbad", 1, 1, 'h60);

    // Run-length saturation.
    do_reset("satrst");
    for (int i = 0; i < RUN_MAX + 5; i++) cycle("runsat", 1, 0, 'h70 + i);

`ifdef MON_HALT_ON_ERR_EN
    do_reset("t6rst");
    cycle("t6", 1, 0, 'h00);
    cycle("t6", 1, 0, 'h01);
    cycle("t6halt", 1, 0, 'h07);
    cycle("t6frz", 1, 0, 'h00);
    cycle("t6frz", 1, 0, 'h80);
    cycle("t6clr", 0, 1, 'h80);
    cycle("t6recap", 1, 0, 'h20);
    cycle("t6lock", 1, 0, 'h21);
`else
    // err_cnt saturation with 300 illegal steps.
    do_reset("t6rst");
    cycle("t6", 1, 0, 'h00);
    for (int i = 0; i < 300; i++) cycle("errsat", 1, 0, (i % 2 == 0) ? 'h80 : 'h00);
    check("errsat.final", mon_if.err_cnt, 255);
`endif

    // Random walk with occasional holds, gaps, jumps and clears.
    do_reset("rndrst");
    cnt = $urandom_range(0, MOD - 1);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 19);
      k = $urandom_range(0, 9);
      if (k < 4)       cnt = (m_prev + 1) % MOD;
      else if (k < 7)  cnt = (m_prev + MOD - 1) % MOD;
      else if (k < 9)  cnt = m_prev;
      else             cnt = (m_prev + $urandom_range(2, MOD - 2)) % MOD;
      if (!m_started) cnt = $urandom_range(0, MOD - 1);
      if ($urandom_range(0, 15) == 0) cnt = (m_prev == 0) ? MOD - 1 : 0;
      cycle("rnd", r != 0, r == 1, cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
